// File: rtl/crc_frm_pkg.sv
// Shared types, widths and helpers for the CRC32 frame-append stage.
package crc_frm_pkg;

   localparam int CRC_W = 32;
   localparam logic [CRC_W-1:0] CRC_XOROUT_DEF = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      PASS   = 2'd0,
      APPEND = 2'd1,
      DRAIN  = 2'd2
   } frm_state_t;

   // Mirror bit i onto bit 31-i (Ethernet FCS transmit order).
   function automatic logic [CRC_W-1:0] bitreverse32(input logic [CRC_W-1:0] v);
      logic [CRC_W-1:0] r;
      r = {CRC_W{1'b0}};
      for (int i = 0; i < CRC_W; i++) begin
         r[i] = v[CRC_W-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc_frm_outreg.sv
// Single-entry valid/ready output register carrying a data word and a last flag.
module crc_frm_outreg
   import crc_frm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CRC_W-1:0] load_data,
   input  logic             load_last,
   input  logic             m_ready,
   output logic [CRC_W-1:0] m_data,
   output logic             m_valid,
   output logic             m_last,
   output logic             free
);

   assign free = !m_valid | m_ready;

   // Load a new word when offered, otherwise empty on an output beat and hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= {CRC_W{1'b0}};
         m_last  <= 1'b0;
      end else if (load) begin
         m_valid <= 1'b1;
         m_data  <= load_data;
         m_last  <= load_last;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end else begin
         m_valid <= m_valid;
      end
   end

endmodule

// File: rtl/crc32_frame_append.sv
// Forwards a 32-bit word stream and appends the finalized CRC32 as the last word of each frame.
// Define CRC_FRM_REFLECT_EN to bit-reverse the engine result before the final XOR.
module crc32_frame_append
   import crc_frm_pkg::*;
#(
   parameter logic [CRC_W-1:0] CRC_XOROUT = CRC_XOROUT_DEF,
   parameter int               LEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CRC_W-1:0] s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic [CRC_W-1:0] m_data,
   output logic             m_valid,
   output logic             m_last,
   input  logic             m_ready,
   output logic [CRC_W-1:0] crc_data_in,
   output logic             crc_en,
   output logic             crc_clr,
   input  logic [CRC_W-1:0] crc_next,
   output logic [LEN_W-1:0] frame_len,
   output logic             frame_done
);

   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   frm_state_t       state;
   frm_state_t       state_next;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cnt_inc;
   logic             clr_q;
   logic [CRC_W-1:0] crc_hold;
   logic [CRC_W-1:0] crc_final;
   logic             out_free;
   logic             in_beat;
   logic             out_beat;
   logic             load;
   logic [CRC_W-1:0] load_data;
   logic             load_last;

   assign cnt_inc = (cnt == LEN_MAX) ? LEN_MAX : cnt + LEN_ONE;

`ifdef CRC_FRM_REFLECT_EN
   assign crc_final = bitreverse32(crc_next) ^ CRC_XOROUT;
`else
   assign crc_final = crc_next ^ CRC_XOROUT;
`endif

   // Input is held off while the engine is being cleared so crc_en never overlaps crc_clr.
   assign s_ready     = !rst & !clr_q & (state == PASS) & out_free;
   assign in_beat     = s_valid & s_ready;
   assign out_beat    = m_valid & m_ready;
   assign crc_data_in = s_data;
   assign crc_en      = in_beat;
   assign crc_clr     = rst | clr_q;
   assign frame_done  = !rst & (state == DRAIN) & out_beat;

   // Next-state and output-register load selection.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      load_data  = s_data;
      load_last  = 1'b0;
      case (state)
         PASS: begin
            if (in_beat) begin
               load = 1'b1;
               if (s_last) begin
                  state_next = APPEND;
               end else begin
                  state_next = PASS;
               end
            end else begin
               state_next = PASS;
            end
         end
         APPEND: begin
            if (out_free) begin
               load       = 1'b1;
               load_data  = crc_hold;
               load_last  = 1'b1;
               state_next = DRAIN;
            end else begin
               state_next = APPEND;
            end
         end
         DRAIN: begin
            if (out_beat) begin
               state_next = PASS;
            end else begin
               state_next = DRAIN;
            end
         end
         default: begin
            state_next = PASS;
         end
      endcase
   end

   // State, word counter, CRC capture and the one-shot engine clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PASS;
         cnt       <= {LEN_W{1'b0}};
         clr_q     <= 1'b1;
         crc_hold  <= {CRC_W{1'b0}};
         frame_len <= {LEN_W{1'b0}};
      end else begin
         state <= state_next;
         clr_q <= in_beat & s_last;
         if (in_beat) begin
            cnt <= cnt_inc;
         end else if (frame_done) begin
            cnt <= {LEN_W{1'b0}};
         end
         // Capture from crc_next before the engine register absorbs the last word.
         if (in_beat & s_last) begin
            crc_hold  <= crc_final;
            frame_len <= cnt_inc;
         end
      end
   end

   crc_frm_outreg u_outreg (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_last    (m_last),
      .free      (out_free)
   );

endmodule

// File: tb/tb_crc32_frame_append.sv
// Randomized self-checking bench for crc32_frame_append against a queue-based frame model.
`timescale 1ns/1ps
module tb_crc32_frame_append;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_data = 32'h0;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic        s_ready;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready = 1'b1;
   logic [31:0] crc_data_in;
   logic        crc_en;
   logic        crc_clr;
   logic [31:0] crc_next = 32'h0;
   logic [15:0] frame_len;
   logic        frame_done;

   crc32_frame_append dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
      .m_ready(m_ready), .crc_data_in(crc_data_in), .crc_en(crc_en), .crc_clr(crc_clr),
      .crc_next(crc_next), .frame_len(frame_len), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

`ifdef CRC_FRM_REFLECT_EN
   localparam logic [31:0] EXP_CRC1 = 32'hE195_D3B7;
`else
   localparam logic [31:0] EXP_CRC1 = 32'hEDCB_A987;
`endif

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int rdy_mode = 0;

   // reference model state
   logic [32:0] exp_q[$];
   logic [32:0] item;
   int  mdl_cnt = 0;
   int  exp_len = 0;
   bit  tail = 0;
   bit  new_frame = 1;
   bit  expect_done = 0;
   bit  prev_stall = 0;
   logic [31:0] prev_data = 32'h0;
   logic prev_last = 1'b0;
   int  en_cnt = 0, clr_cnt = 0, done_cnt = 0, out_cnt = 0;
   int  done_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0, clr_cyc = 0;
   logic [31:0] last_crc_word = 32'h0;

   function automatic logic [31:0] ref_crc(input logic [31:0] c);
      logic [31:0] r;
`ifdef CRC_FRM_REFLECT_EN
      for (int i = 0; i < 32; i++) r[i] = c[31-i];
`else
      r = c;
`endif
      return r ^ 32'hFFFF_FFFF;
   endfunction

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: m_ready = 1'b1;
         1: m_ready = ~m_ready;
         2: m_ready = 1'($urandom_range(0, 1));
         default: m_ready = 1'b1;
      endcase
   end

   // Scoreboard: expected output words, handshake rules and frame bookkeeping.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_q.delete();
         mdl_cnt = 0; exp_len = 0; tail = 0; prev_stall = 0; new_frame = 1;
      end else begin
         expect_done = 0;
         if (crc_clr) begin clr_cnt++; clr_cyc = cyc; end
         if (crc_en) en_cnt++;
         vectors++;
         if (crc_en && crc_clr) begin
            miscompares++;
            $display("FAIL en_clr_overlap cyc=%0d: crc_en=%b crc_clr=%b, required not both 1", cyc, crc_en, crc_clr);
         end
         vectors++;
         if (crc_en !== (s_valid & s_ready)) begin
            miscompares++;
            $display("FAIL crc_en cyc=%0d: got %b required %b", cyc, crc_en, s_valid & s_ready);
         end
         vectors++;
         if (crc_data_in !== s_data) begin
            miscompares++;
            $display("FAIL crc_data_in: got %h required %h", crc_data_in, s_data);
         end
         if (prev_stall) begin
            vectors++;
            if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
               miscompares++;
               $display("FAIL stall_hold cyc=%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                        cyc, m_valid, m_data, m_last, prev_data, prev_last);
            end
         end
         if (tail) begin
            vectors++;
            if (s_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL tail_ready cyc=%0d: s_ready=%b required 0", cyc, s_ready);
            end
         end
         vectors++;
         if (frame_len !== exp_len[15:0]) begin
            miscompares++;
            $display("FAIL frame_len cyc=%0d: got %0d required %0d", cyc, frame_len, exp_len);
         end
         if (m_valid && m_ready) begin
            out_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_out cyc=%0d: got %h with nothing expected", cyc, m_data);
            end else begin
               item = exp_q.pop_front();
               if ({m_last, m_data} !== item) begin
                  miscompares++;
                  $display("FAIL out_word cyc=%0d: got l=%b d=%h required l=%b d=%h",
                           cyc, m_last, m_data, item[32], item[31:0]);
               end
               if (item[32]) begin
                  last_crc_word = m_data;
                  expect_done = 1;
               end
            end
         end
         vectors++;
         if (frame_done !== expect_done) begin
            miscompares++;
            $display("FAIL frame_done cyc=%0d: got %b required %b", cyc, frame_done, expect_done);
         end
         if (expect_done) begin
            done_cnt++; done_cyc = cyc; tail = 0;
         end
         if (s_valid && s_ready) begin
            if (new_frame) begin first_beat_cyc = cyc; new_frame = 0; end
            exp_q.push_back({1'b0, s_data});
            mdl_cnt = (mdl_cnt < 65535) ? mdl_cnt + 1 : 65535;
            if (s_last) begin
               exp_q.push_back({1'b1, ref_crc(crc_next)});
               exp_len = mdl_cnt; mdl_cnt = 0; tail = 1; new_frame = 1;
               last_beat_cyc = cyc;
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data = m_data;
         prev_last = m_last;
      end
   end

   task automatic send_word(input logic [31:0] d, input logic last, input logic [31:0] cn);
      bit ok = 0;
      s_valid = 1'b1; s_data = d; s_last = last; crc_next = cn;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (s_ready === 1'b1) ok = 1;
         @(posedge clk); #1;
      end
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout: word %h never accepted", d);
      end
   endtask

   task automatic wait_done(input int d0, input int bound);
      bit seen = 0;
      for (int n = 0; n < bound && !seen; n++) begin
         @(negedge clk); #1;
         if (done_cnt != d0) seen = 1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL done_timeout: frame_done not seen in %0d cycles", bound);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({m_valid, m_last, m_data, frame_len, frame_done, crc_clr, s_ready} !== {1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_values: v=%b l=%b d=%h len=%0d done=%b clr=%b rdy=%b required 0 0 0 0 0 1 0",
                  m_valid, m_last, m_data, frame_len, frame_done, crc_clr, s_ready);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (crc_clr !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_clr: clr=%b rdy=%b v=%b required 1 0 0", crc_clr, s_ready, m_valid);
      end
      @(negedge clk);
      vectors++;
      if (crc_clr !== 1'b0 || s_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_ready: clr=%b rdy=%b required 0 1", crc_clr, s_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_midframe_reset();
      rdy_mode = 0;
      send_word($urandom, 1'b0, $urandom);
      send_word($urandom, 1'b0, $urandom);
      s_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (m_valid !== 1'b0 || crc_clr !== 1'b1 || s_ready !== 1'b0 || frame_len !== 16'd0) begin
         miscompares++;
         $display("FAIL midframe_reset: v=%b clr=%b rdy=%b len=%0d required 0 1 0 0",
                  m_valid, crc_clr, s_ready, frame_len);
      end
      @(negedge clk);
      vectors++;
      if (s_ready !== 1'b1 || crc_clr !== 1'b0) begin
         miscompares++;
         $display("FAIL midframe_pass: rdy=%b clr=%b required 1 0", s_ready, crc_clr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_three_word();
      int e0 = en_cnt, c0 = clr_cnt, d0 = done_cnt;
      rdy_mode = 0;
      send_word(32'h1111_1111, 1'b0, $urandom);
      send_word(32'h2222_2222, 1'b0, $urandom);
      send_word(32'h3333_3333, 1'b1, 32'h1234_5678);
      s_valid = 1'b0;
      wait_done(d0, 50);
      vectors++;
      if (last_crc_word !== EXP_CRC1) begin
         miscompares++;
         $display("FAIL three_crc: got %h required %h", last_crc_word, EXP_CRC1);
      end
      vectors++;
      if (en_cnt - e0 != 3 || clr_cnt - c0 != 1 || clr_cyc != last_beat_cyc + 1) begin
         miscompares++;
         $display("FAIL three_strobes: en=%0d clr=%0d clr_at=+%0d required 3 1 +1",
                  en_cnt - e0, clr_cnt - c0, clr_cyc - last_beat_cyc);
      end
      vectors++;
      if (frame_len !== 16'd3 || done_cnt - d0 != 1 || last_beat_cyc - first_beat_cyc != 2) begin
         miscompares++;
         $display("FAIL three_len: len=%0d done=%0d span=%0d required 3 1 2",
                  frame_len, done_cnt - d0, last_beat_cyc - first_beat_cyc);
      end
   endtask

   task automatic test_single_word();
      int d0 = done_cnt;
      rdy_mode = 0;
      send_word(32'hDEAD_BEEF, 1'b1, 32'h0);
      s_valid = 1'b0;
      wait_done(d0, 50);
      vectors++;
      if (last_crc_word !== 32'hFFFF_FFFF || frame_len !== 16'd1 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL single: crc=%h len=%0d left=%0d required ffffffff 1 0",
                  last_crc_word, frame_len, exp_q.size());
      end
   endtask

   task automatic test_stall();
      int d0 = done_cnt, o0 = out_cnt;
      rdy_mode = 1;
      for (int i = 0; i < 4; i++) send_word($urandom, 1'(i == 3), $urandom);
      s_valid = 1'b0;
      wait_done(d0, 100);
      rdy_mode = 0;
      vectors++;
      if (out_cnt - o0 != 5 || exp_q.size() != 0 || frame_len !== 16'd4) begin
         miscompares++;
         $display("FAIL stall_frame: outs=%0d left=%0d len=%0d required 5 0 4",
                  out_cnt - o0, exp_q.size(), frame_len);
      end
   endtask

   task automatic test_back_to_back();
      int d0 = done_cnt;
      rdy_mode = 0;
      for (int i = 0; i < 3; i++) send_word($urandom, 1'(i == 2), $urandom);
      send_word($urandom, 1'b0, $urandom);
      vectors++;
      if (first_beat_cyc != done_cyc + 1) begin
         miscompares++;
         $display("FAIL b2b_restart: first beat %0d cycles after frame_done, required 1",
                  first_beat_cyc - done_cyc);
      end
      send_word($urandom, 1'b1, $urandom);
      s_valid = 1'b0;
      wait_done(d0 + 1, 50);
      vectors++;
      if (done_cnt - d0 != 2 || frame_len !== 16'd2) begin
         miscompares++;
         $display("FAIL b2b_frames: done=%0d len=%0d required 2 2", done_cnt - d0, frame_len);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 8; f++) begin
         int len = $urandom_range(1, 6);
         int d0 = done_cnt;
         logic [31:0] cn = $urandom;
         rdy_mode = 2;
         for (int i = 0; i < len; i++) begin
            int g = $urandom_range(0, 2);
            if (g != 0) begin
               s_valid = 1'b0;
               repeat (g) @(posedge clk);
               #1;
            end
            send_word($urandom, 1'(i == len - 1), (i == len - 1) ? cn : $urandom);
         end
         s_valid = 1'b0;
         wait_done(d0, 200);
         vectors++;
         if (last_crc_word !== ref_crc(cn) || frame_len !== 16'(len) || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL random_frame %0d: crc=%h len=%0d left=%0d required %h %0d 0",
                     f, last_crc_word, frame_len, exp_q.size(), ref_crc(cn), len);
         end
      end
      rdy_mode = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_midframe_reset();
      test_three_word();
      test_single_word();
      test_stall();
      test_back_to_back();
      test_random();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
